// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU control sequencer: operation codes, FSM states and
// the packed bundle of datapath control strobes.
package alu_ctrl_pkg;

  localparam int unsigned CTRL_W = 5;

  typedef logic [CTRL_W-1:0] op_t;

  localparam op_t LOAD   = op_t'(0);
  localparam op_t ADD    = op_t'(1);
  localparam op_t SUB    = op_t'(2);
  localparam op_t AND_OP = op_t'(3);
  localparam op_t INC    = op_t'(4);
  localparam op_t NOT_OP = op_t'(5);
  localparam op_t XOR_OP = op_t'(6);
  localparam op_t SLT    = op_t'(7);
  localparam op_t OR_OP  = op_t'(8);
  localparam op_t DIV    = op_t'(9);
  localparam op_t MULT   = op_t'(10);
  localparam op_t ADDU   = op_t'(11);
  localparam op_t MFHI   = op_t'(12);
  localparam op_t MFLO   = op_t'(13);
  localparam op_t BEQ    = op_t'(14);
  localparam op_t BNE    = op_t'(15);
  localparam op_t BLEZ   = op_t'(16);
  localparam op_t BGTZ   = op_t'(17);
  localparam op_t SFT    = op_t'(18);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    MD_START,
    MD_WAIT,
    MD_STORE
  } state_t;

  typedef struct packed {
    logic [1:0] cond_type;
    logic       div_op;
    logic       mult_op;
    logic [2:0] alu_op;
    logic       or_op;
    logic       overflow_op;
    logic [2:0] src_out;
    logic [1:0] store_md;
    logic       alu_out_save;
  } ctrl_t;

  localparam ctrl_t CTRL_ZERO = '0;

  // HI/LO write strobe: div results land as 01, mult results as 10.
  function automatic logic [1:0] store_code(input logic is_div);
    return is_div ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request handshake between the main control FSM (master) and the sequencer (slave).
interface alu_ctrl_seq_if;
  import alu_ctrl_pkg::*;

  logic              req_valid;
  logic [CTRL_W-1:0] req_type;
  logic              req_ready;

  modport master (output req_valid, output req_type, input req_ready);
  modport slave  (input req_valid, input req_type, output req_ready);

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational operation-code decode into control strobes plus mult/div and
// illegal-code classification.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [CTRL_W-1:0] code,
  output ctrl_t             ctrl,
  output logic              is_md,
  output logic              is_div,
  output logic              is_illegal
);

  always_comb begin
    ctrl       = CTRL_ZERO;
    is_md      = 1'b0;
    is_div     = 1'b0;
    is_illegal = 1'b0;
    unique case (code)
      LOAD:   begin ctrl.alu_op = 3'b000; ctrl.src_out = 3'b011; ctrl.alu_out_save = 1'b1; end
      ADD:    begin ctrl.alu_op = 3'b001; ctrl.src_out = 3'b011; ctrl.overflow_op = 1'b1; ctrl.alu_out_save = 1'b1; end
      SUB:    begin ctrl.alu_op = 3'b010; ctrl.src_out = 3'b011; ctrl.overflow_op = 1'b1; ctrl.alu_out_save = 1'b1; end
      AND_OP: begin ctrl.alu_op = 3'b011; ctrl.src_out = 3'b011; ctrl.alu_out_save = 1'b1; end
      INC:    begin ctrl.alu_op = 3'b100; ctrl.src_out = 3'b011; ctrl.overflow_op = 1'b1; ctrl.alu_out_save = 1'b1; end
      NOT_OP: begin ctrl.alu_op = 3'b101; ctrl.src_out = 3'b011; ctrl.alu_out_save = 1'b1; end
      XOR_OP: begin ctrl.alu_op = 3'b110; ctrl.src_out = 3'b011; ctrl.alu_out_save = 1'b1; end
      SLT:    begin ctrl.alu_op = 3'b111; ctrl.src_out = 3'b010; ctrl.alu_out_save = 1'b1; end
      OR_OP:  begin ctrl.or_op = 1'b1; ctrl.src_out = 3'b100; ctrl.alu_out_save = 1'b1; end
      DIV:    begin is_md = 1'b1; is_div = 1'b1; end
      MULT:   is_md = 1'b1;
      ADDU:   begin ctrl.alu_op = 3'b001; ctrl.src_out = 3'b011; ctrl.alu_out_save = 1'b1; end
      MFHI:   begin ctrl.src_out = 3'b001; ctrl.alu_out_save = 1'b1; end
      MFLO:   begin ctrl.src_out = 3'b000; ctrl.alu_out_save = 1'b1; end
      BEQ:    ctrl.cond_type = 2'b00;
      BNE:    ctrl.cond_type = 2'b01;
      BLEZ:   ctrl.cond_type = 2'b10;
      BGTZ:   ctrl.cond_type = 2'b11;
      SFT:    begin ctrl.src_out = 3'b110; ctrl.alu_out_save = 1'b1; end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Handshaked ALU control sequencer: registers decoded strobes for single-cycle
// ops and walks mult/div ops through start, wait (with watchdog) and store.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 40
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  alu_ctrl_seq_if.slave       req,
  input  logic                md_done,
  output logic [1:0]          condType,
  output logic                divOp,
  output logic                multOp,
  output logic [2:0]          ALUOp,
  output logic                orOp,
  output logic                overflowOp,
  output logic [2:0]          SrcOut,
  output logic [1:0]          StoreMD,
  output logic                ALUOutSave,
  output logic                busy,
  output logic                err_illegal,
  output logic                err_timeout
);

  localparam int unsigned CNT_W    = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t           state;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] wd_cnt;

  ctrl_t dec_ctrl;
  logic  dec_md;
  logic  dec_div;
  logic  dec_illegal;
  ctrl_t md_ctrl;
  ctrl_t store_ctrl;
  logic  accept;

  alu_ctrl_decode u_decode (
    .code       (req.req_type),
    .ctrl       (dec_ctrl),
    .is_md      (dec_md),
    .is_div     (dec_div),
    .is_illegal (dec_illegal)
  );

  // Flush blocks acceptance in the same cycle so an aborted request is never taken.
  assign req.req_ready = ((state == IDLE) || (state == ISSUE)) && !flush;
  assign accept        = req.req_valid && req.req_ready;

  // Strobe patterns for entering MD_START and MD_STORE.
  always_comb begin
    md_ctrl            = CTRL_ZERO;
    md_ctrl.div_op     = dec_div;
    md_ctrl.mult_op    = !dec_div;
    store_ctrl          = CTRL_ZERO;
    store_ctrl.store_md = store_code(ctrl_q.div_op);
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      state       <= IDLE;
      ctrl_q      <= CTRL_ZERO;
      wd_cnt      <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        IDLE, ISSUE: begin
          if (accept && dec_illegal) begin
            state       <= IDLE;
            ctrl_q      <= CTRL_ZERO;
            err_illegal <= 1'b1;
          end else if (accept && dec_md) begin
            state  <= MD_START;
            ctrl_q <= md_ctrl;
          end else if (accept) begin
            state  <= ISSUE;
            ctrl_q <= dec_ctrl;
          end else begin
            state  <= IDLE;
            ctrl_q <= CTRL_ZERO;
          end
        end
        MD_START: begin
          if (md_done) begin
            state  <= MD_STORE;
            ctrl_q <= store_ctrl;
          end else begin
            state  <= MD_WAIT;
            wd_cnt <= '0;
          end
        end
        MD_WAIT: begin
          // A completion on the last watchdog cycle still wins over the timeout.
          if (md_done) begin
            state  <= MD_STORE;
            ctrl_q <= store_ctrl;
          end else if (wd_cnt == CNT_LAST) begin
            state       <= IDLE;
            ctrl_q      <= CTRL_ZERO;
            err_timeout <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        MD_STORE: begin
          state  <= IDLE;
          ctrl_q <= CTRL_ZERO;
        end
        default: begin
          state  <= IDLE;
          ctrl_q <= CTRL_ZERO;
        end
      endcase
    end
  end

  assign condType   = ctrl_q.cond_type;
  assign divOp      = ctrl_q.div_op;
  assign multOp     = ctrl_q.mult_op;
  assign ALUOp      = ctrl_q.alu_op;
  assign orOp       = ctrl_q.or_op;
  assign overflowOp = ctrl_q.overflow_op;
  assign SrcOut     = ctrl_q.src_out;
  assign StoreMD    = ctrl_q.store_md;
  assign ALUOutSave = ctrl_q.alu_out_save;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed-vector bench for alu_ctrl_seq with hand-computed expected strobes.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  logic md_done;
  logic [1:0] condType;
  logic divOp, multOp;
  logic [2:0] ALUOp;
  logic orOp, overflowOp;
  logic [2:0] SrcOut;
  logic [1:0] StoreMD;
  logic ALUOutSave, busy, err_illegal, err_timeout;

  int n_vec = 0;
  int n_err = 0;

  alu_ctrl_seq_if rq ();

  alu_ctrl_seq #(.MD_TIMEOUT(40)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .req         (rq.slave),
    .md_done     (md_done),
    .condType    (condType),
    .divOp       (divOp),
    .multOp      (multOp),
    .ALUOp       (ALUOp),
    .orOp        (orOp),
    .overflowOp  (overflowOp),
    .SrcOut      (SrcOut),
    .StoreMD     (StoreMD),
    .ALUOutSave  (ALUOutSave),
    .busy        (busy),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Output vector order: cond, div, mult, alu, or, ovf, src, store, save.
  wire [14:0] outs = {condType, divOp, multOp, ALUOp, orOp, overflowOp,
                      SrcOut, StoreMD, ALUOutSave};

  function automatic logic [14:0] e(input int c, input int d, input int m, input int a,
                                    input int o, input int v, input int s, input int st,
                                    input int sv);
    return {2'(c), 1'(d), 1'(m), 3'(a), 1'(o), 1'(v), 3'(s), 2'(st), 1'(sv)};
  endfunction

  // Hand-computed strobes for every single-cycle code.
  function automatic logic [14:0] exp_issue(input int code);
    case (code)
      0:  return e(0, 0, 0, 0, 0, 0, 3, 0, 1);
      1:  return e(0, 0, 0, 1, 0, 1, 3, 0, 1);
      2:  return e(0, 0, 0, 2, 0, 1, 3, 0, 1);
      3:  return e(0, 0, 0, 3, 0, 0, 3, 0, 1);
      4:  return e(0, 0, 0, 4, 0, 1, 3, 0, 1);
      5:  return e(0, 0, 0, 5, 0, 0, 3, 0, 1);
      6:  return e(0, 0, 0, 6, 0, 0, 3, 0, 1);
      7:  return e(0, 0, 0, 7, 0, 0, 2, 0, 1);
      8:  return e(0, 0, 0, 0, 1, 0, 4, 0, 1);
      11: return e(0, 0, 0, 1, 0, 0, 3, 0, 1);
      12: return e(0, 0, 0, 0, 0, 0, 1, 0, 1);
      13: return e(0, 0, 0, 0, 0, 0, 0, 0, 1);
      14: return e(0, 0, 0, 0, 0, 0, 0, 0, 0);
      15: return e(1, 0, 0, 0, 0, 0, 0, 0, 0);
      16: return e(2, 0, 0, 0, 0, 0, 0, 0, 0);
      17: return e(3, 0, 0, 0, 0, 0, 0, 0, 0);
      18: return e(0, 0, 0, 0, 0, 0, 6, 0, 1);
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int code);
    rq.req_valid = 1'b1;
    rq.req_type  = 5'(code);
  endtask

  task automatic idle_req();
    rq.req_valid = 1'b0;
    rq.req_type  = 5'd0;
  endtask

  // Accept a mult/div code and advance into MD_WAIT (first MD_WAIT cycle observed).
  task automatic to_md_wait(input int code);
    send(code);
    tick();
    idle_req();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int mult_hi;
    logic saw_store;

    reset_n = 1'b0;
    flush   = 1'b0;
    md_done = 1'b0;
    send(1);
    tick();
    tick();
    chk("rst_outs", 32'(outs), 32'(0));
    chk("rst_ready", 32'(rq.req_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_errs", 32'({err_illegal, err_timeout}), 32'(0));

    // First accept after reset: ADD
    reset_n = 1'b1;
    tick();
    chk("first_add", 32'(outs), 32'(e(0, 0, 0, 1, 0, 1, 3, 0, 1)));
    chk("first_add_busy", 32'(busy), 32'(1));

    // Back-to-back SLT, SFT, BNE
    send(7);  tick();
    chk("b2b_slt", 32'(outs), 32'(e(0, 0, 0, 7, 0, 0, 2, 0, 1)));
    chk("b2b_ready", 32'(rq.req_ready), 32'(1));
    send(18); tick();
    chk("b2b_sft", 32'(outs), 32'(e(0, 0, 0, 0, 0, 0, 6, 0, 1)));
    send(15); tick();
    chk("b2b_bne", 32'(outs), 32'(e(1, 0, 0, 0, 0, 0, 0, 0, 0)));
    idle_req(); tick();
    chk("issue_to_idle", 32'({busy, outs}), 32'(0));

    // Sweep all single-cycle codes back to back
    for (int c = 0; c <= 18; c++) begin
      if (c == 9 || c == 10) continue;
      send(c);
      tick();
      chk($sformatf("decode_%0d", c), 32'(outs), 32'(exp_issue(c)));
    end
    idle_req(); tick();

    // Mult with md_done five cycles after MD_START
    mult_hi = 0;
    send(10); tick(); idle_req();
    chk("mult_start", 32'(outs), 32'(e(0, 0, 1, 0, 0, 0, 0, 0, 0)));
    chk("mult_ready", 32'(rq.req_ready), 32'(0));
    if (multOp) mult_hi++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (multOp) mult_hi++;
    end
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("mult_hi_cycles", 32'(mult_hi), 32'(6));
    chk("mult_store", 32'(outs), 32'(e(0, 0, 0, 0, 0, 0, 0, 2, 0)));
    chk("mult_store_ready", 32'(rq.req_ready), 32'(0));
    tick();
    chk("mult_done_idle", 32'({busy, outs}), 32'(0));
    chk("mult_ready_back", 32'(rq.req_ready), 32'(1));

    // Div completing in MD_START goes straight to store
    md_done = 1'b1;
    send(9); tick(); idle_req();
    chk("div_start", 32'(outs), 32'(e(0, 1, 0, 0, 0, 0, 0, 0, 0)));
    tick();
    md_done = 1'b0;
    chk("div_fast_store", 32'(outs), 32'(e(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    tick();
    chk("div_fast_idle", 32'(busy), 32'(0));

    // Div timeout: err_timeout 40 cycles after MD_WAIT entry
    to_md_wait(9);
    chk("div_wait", 32'(outs), 32'(e(0, 1, 0, 0, 0, 0, 0, 0, 0)));
    n = 0;
    saw_store = 1'b0;
    while (n < 60 && !err_timeout) begin
      tick();
      n++;
      if (StoreMD != 2'b00) saw_store = 1'b1;
    end
    chk("timeout_cycles", 32'(n), 32'(40));
    chk("timeout_no_store", 32'(saw_store), 32'(0));
    chk("timeout_idle", 32'({busy, outs}), 32'(0));
    chk("timeout_ready", 32'(rq.req_ready), 32'(1));
    tick();
    chk("timeout_pulse", 32'(err_timeout), 32'(0));

    // md_done on the last watchdog cycle wins
    to_md_wait(9);
    for (int i = 0; i < 39; i++) tick();
    md_done = 1'b1;
    tick();
    md_done = 1'b0;
    chk("edge_done_store", 32'(outs), 32'(e(0, 0, 0, 0, 0, 0, 0, 1, 0)));
    chk("edge_done_no_to", 32'(err_timeout), 32'(0));
    tick();

    // Illegal code, then an immediate legal one
    send(31); tick();
    chk("illegal_pulse", 32'(err_illegal), 32'(1));
    chk("illegal_outs", 32'({busy, outs}), 32'(0));
    chk("illegal_ready", 32'(rq.req_ready), 32'(1));
    send(2); tick();
    chk("after_illegal", 32'(outs), 32'(e(0, 0, 0, 2, 0, 1, 3, 0, 1)));
    chk("illegal_one_pulse", 32'(err_illegal), 32'(0));
    idle_req(); tick();

    // Flush during MD_WAIT
    to_md_wait(10);
    tick();
    flush = 1'b1;
    #1;
    chk("flush_ready_low", 32'(rq.req_ready), 32'(0));
    tick();
    flush = 1'b0;
    chk("flush_idle", 32'({busy, outs}), 32'(0));
    tick();
    chk("flush_no_store", 32'(StoreMD), 32'(0));

    // Flush coinciding with md_done
    to_md_wait(10);
    flush   = 1'b1;
    md_done = 1'b1;
    tick();
    flush   = 1'b0;
    md_done = 1'b0;
    chk("flush_done_idle", 32'({busy, outs}), 32'(0));
    tick();
    chk("flush_done_nostore", 32'(StoreMD), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
